voice_allocator: RTL and testbench

- Control-side partner of the per-voice ADSR envelope. Accepts MIDI-derived note-on/note-off events and assigns each note to a voice slot, stealing a voice when all slots are busy.
- Holds a per-voice table of key state, note and velocity.
- Continuously sweeps voice_index through all slots on the same 2-clock cadence as the envelope. For each slot it presents key_state, note and velocity to the envelope and oscillator stages.

---
 rtl/voice_allocator_pkg.sv | 26 ++
 rtl/voice_table.sv | 87 ++++++++
 rtl/voice_allocator.sv | 253 +++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared constants, event/FSM encodings and index helper for the voice allocator slice.
package voice_allocator_pkg;

  localparam int MIDI_NOTE_W = 7;
  localparam int MIDI_VEL_W  = 7;
  localparam int VOICE_IDX_W = 8;

  typedef logic [MIDI_NOTE_W-1:0] note_t;
  typedef logic [MIDI_VEL_W-1:0]  vel_t;
  typedef logic [VOICE_IDX_W-1:0] vidx_t;

  typedef enum logic {
    EV_OFF = 1'b0,
    EV_ON  = 1'b1
  } ev_type_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Bits needed to address an n-entry table (never below 1).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_table.sv
// Per-voice key/note/velocity/age store with a sweep read port, a scan read port,
// one write port and a saturating age update applied on every allocator commit.
module voice_table
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int AGE_W      = 8,
  parameter int IW         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IW-1:0]    sweep_idx,
  output logic             sweep_key,
  output note_t            sweep_note,
  output vel_t             sweep_vel,
  input  logic [IW-1:0]    scan_idx,
  output logic             scan_key,
  output note_t            scan_note,
  output logic [AGE_W-1:0] scan_age,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic             wr_key,
  input  note_t            wr_note,
  input  vel_t             wr_vel,
  input  logic             wr_vel_en,
  input  logic             age_inc,
  input  logic             clr_keys
);

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  logic             key_q  [NUM_VOICES];
  logic             key_d  [NUM_VOICES];
  note_t            note_q [NUM_VOICES];
  note_t            note_d [NUM_VOICES];
  vel_t             vel_q  [NUM_VOICES];
  vel_t             vel_d  [NUM_VOICES];
  logic [AGE_W-1:0] age_q  [NUM_VOICES];
  logic [AGE_W-1:0] age_d  [NUM_VOICES];

  assign sweep_key  = key_q[sweep_idx];
  assign sweep_note = note_q[sweep_idx];
  assign sweep_vel  = vel_q[sweep_idx];
  assign scan_key   = key_q[scan_idx];
  assign scan_note  = note_q[scan_idx];
  assign scan_age   = age_q[scan_idx];

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      key_d[i]  = key_q[i];
      note_d[i] = note_q[i];
      vel_d[i]  = vel_q[i];
      age_d[i]  = age_q[i];
      if (wr_en && (wr_idx == IW'(i))) begin
        key_d[i]  = wr_key;
        note_d[i] = wr_note;
        age_d[i]  = '0;
        if (wr_vel_en) begin
          vel_d[i] = wr_vel;
        end
      end else if (age_inc && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
      // Panic wins over any write; only the key bits are touched.
      if (clr_keys) begin
        key_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        key_q[i]  <= 1'b0;
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= AGE_MAX;
      end
    end else begin
      key_q  <= key_d;
      note_q <= note_d;
      vel_q  <= vel_d;
      age_q  <= age_d;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Note-event voice allocator: a 2-clock-per-slot sweep feeding the envelope stage and an
// IDLE/SCAN/COMMIT FSM that matches, allocates or steals a voice slot per event.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int AGE_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ev_valid,
  output logic                   ev_ready,
  input  logic                   ev_on,
  input  logic [MIDI_NOTE_W-1:0] ev_note,
  input  logic [MIDI_VEL_W-1:0]  ev_velocity,
  input  logic                   panic,
  output logic [VOICE_IDX_W-1:0] voice_index,
  output logic                   slot_phase,
  output logic                   frame_start,
  output logic                   key_state,
  output logic [MIDI_NOTE_W-1:0] voice_note,
  output logic [MIDI_VEL_W-1:0]  voice_velocity
);

  localparam int          IW        = idx_w(NUM_VOICES);
  localparam vidx_t       LAST_IDX  = VOICE_IDX_W'(NUM_VOICES - 1);
  localparam logic [IW-1:0] LAST_SCAN = IW'(NUM_VOICES - 1);

  // Sweep: slot_phase toggles each clock; index and outputs advance on the 1->0 phase edge.
  vidx_t idx_q, idx_d, idx_next;
  logic  phase_q, phase_d;
  logic  frame_q, frame_d;
  logic  key_q, key_d;
  note_t note_q, note_d;
  vel_t  vel_q, vel_d;

  logic  sw_key;
  note_t sw_note;
  vel_t  sw_vel;

  always_comb begin
    idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + VOICE_IDX_W'(1);
    phase_d  = ~phase_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    key_d    = key_q;
    note_d   = note_q;
    vel_d    = vel_q;
    if (phase_q) begin
      idx_d   = idx_next;
      frame_d = (idx_next == '0);
      key_d   = sw_key;
      note_d  = sw_note;
      vel_d   = sw_vel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      phase_q <= 1'b0;
      frame_q <= 1'b1;
      key_q   <= 1'b0;
      note_q  <= '0;
      vel_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      key_q   <= key_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
    end
  end

  assign voice_index    = idx_q;
  assign slot_phase     = phase_q;
  assign frame_start    = frame_q;
  assign key_state      = key_q;
  assign voice_note     = note_q;
  assign voice_velocity = vel_q;

  // Event FSM. Handshake: an event transfers on a clock edge where ev_valid && ev_ready;
  // ev_ready is high only in IDLE with panic low, and does not depend on ev_valid.
  logic [1:0]       state_q, state_d;
  ev_type_t         ev_on_q, ev_on_d;
  note_t            ev_note_q, ev_note_d;
  vel_t             ev_vel_q, ev_vel_d;
  logic [IW-1:0]    scan_ptr_q, scan_ptr_d;
  logic             match_found_q, match_found_d;
  logic [IW-1:0]    match_idx_q, match_idx_d;
  logic             free_found_q, free_found_d;
  logic [IW-1:0]    free_idx_q, free_idx_d;
  logic [AGE_W-1:0] free_age_q, free_age_d;
  logic             steal_found_q, steal_found_d;
  logic [IW-1:0]    steal_idx_q, steal_idx_d;
  logic [AGE_W-1:0] steal_age_q, steal_age_d;

  logic             scan_key;
  note_t            scan_note;
  logic [AGE_W-1:0] scan_age;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic             wr_key;
  logic             wr_vel_en;
  logic             age_inc;

  always_comb begin
    state_d       = state_q;
    ev_on_d       = ev_on_q;
    ev_note_d     = ev_note_q;
    ev_vel_d      = ev_vel_q;
    scan_ptr_d    = scan_ptr_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    free_age_d    = free_age_q;
    steal_found_d = steal_found_q;
    steal_idx_d   = steal_idx_q;
    steal_age_d   = steal_age_q;
    ev_ready      = (state_q == ST_IDLE) && !panic;
    wr_en         = 1'b0;
    wr_idx        = match_idx_q;
    wr_key        = 1'b1;
    wr_vel_en     = 1'b1;
    age_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ev_valid && ev_ready) begin
          ev_on_d       = ev_type_t'(ev_on);
          ev_note_d     = ev_note;
          ev_vel_d      = ev_velocity;
          scan_ptr_d    = '0;
          match_found_d = 1'b0;
          match_idx_d   = '0;
          free_found_d  = 1'b0;
          free_idx_d    = '0;
          free_age_d    = '0;
          steal_found_d = 1'b0;
          steal_idx_d   = '0;
          steal_age_d   = '0;
          state_d       = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_key && (scan_note == ev_note_q) && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_ptr_q;
        end
        // Strict greater-than keeps the lowest index on equal ages.
        if (!scan_key && (!free_found_q || (scan_age > free_age_q))) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_ptr_q;
          free_age_d   = scan_age;
        end
        if (scan_key && (!steal_found_q || (scan_age > steal_age_q))) begin
          steal_found_d = 1'b1;
          steal_idx_d   = scan_ptr_q;
          steal_age_d   = scan_age;
        end
        scan_ptr_d = scan_ptr_q + IW'(1);
        if (scan_ptr_q == LAST_SCAN) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        age_inc = 1'b1;
        state_d = ST_IDLE;
        if (ev_on_q == EV_ON) begin
          wr_en = 1'b1;
          if (match_found_q) begin
            wr_idx = match_idx_q;
          end else if (free_found_q) begin
            wr_idx = free_idx_q;
          end else begin
            wr_idx = steal_idx_q;
          end
        end else begin
          wr_en     = match_found_q;
          wr_key    = 1'b0;
          wr_vel_en = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (panic) begin
      state_d = ST_IDLE;
      wr_en   = 1'b0;
      age_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ev_on_q       <= EV_OFF;
      ev_note_q     <= '0;
      ev_vel_q      <= '0;
      scan_ptr_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      free_age_q    <= '0;
      steal_found_q <= 1'b0;
      steal_idx_q   <= '0;
      steal_age_q   <= '0;
    end else begin
      state_q       <= state_d;
      ev_on_q       <= ev_on_d;
      ev_note_q     <= ev_note_d;
      ev_vel_q      <= ev_vel_d;
      scan_ptr_q    <= scan_ptr_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      free_age_q    <= free_age_d;
      steal_found_q <= steal_found_d;
      steal_idx_q   <= steal_idx_d;
      steal_age_q   <= steal_age_d;
    end
  end

  voice_table #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IW         (IW)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .sweep_idx  (idx_next[IW-1:0]),
    .sweep_key  (sw_key),
    .sweep_note (sw_note),
    .sweep_vel  (sw_vel),
    .scan_idx   (scan_ptr_q),
    .scan_key   (scan_key),
    .scan_note  (scan_note),
    .scan_age   (scan_age),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_key     (wr_key),
    .wr_note    (ev_note_q),
    .wr_vel     (ev_vel_q),
    .wr_vel_en  (wr_vel_en),
    .age_inc    (age_inc),
    .clr_keys   (panic)
  );

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: reference voice table model, per-frame expected queue
// popped by a sweep monitor, plus direct checks of sweep timing, ready latency and panic.
module tb_voice_allocator;

  localparam int NV = 16;
  localparam int EW = 23;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_on = 1'b0;
  logic [6:0] ev_note = '0;
  logic [6:0] ev_velocity = '0;
  logic       panic = 1'b0;
  logic       ev_ready;
  logic [7:0] voice_index;
  logic       slot_phase;
  logic       frame_start;
  logic       key_state;
  logic [6:0] voice_note;
  logic [6:0] voice_velocity;

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  int m_key[NV];
  int m_note[NV];
  int m_vel[NV];
  int m_age[NV];

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_on          (ev_on),
    .ev_note        (ev_note),
    .ev_velocity    (ev_velocity),
    .panic          (panic),
    .voice_index    (voice_index),
    .slot_phase     (slot_phase),
    .frame_start    (frame_start),
    .key_state      (key_state),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_key[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 255;
    end
  endtask

  task automatic model_apply(input logic on, input int n, input int v);
    int match = -1;
    int fr = -1;
    int st = -1;
    int w = -1;
    for (int i = 0; i < NV; i++) begin
      if (m_key[i] == 1 && m_note[i] == n && match < 0) match = i;
      if (m_key[i] == 0 && (fr < 0 || m_age[i] > m_age[fr])) fr = i;
      if (m_key[i] == 1 && (st < 0 || m_age[i] > m_age[st])) st = i;
    end
    if (on) begin
      w = (match >= 0) ? match : ((fr >= 0) ? fr : st);
      m_key[w] = 1; m_note[w] = n; m_vel[w] = v;
    end else if (match >= 0) begin
      w = match;
      m_key[w] = 0;
    end
    for (int i = 0; i < NV; i++) begin
      if (i == w) m_age[i] = 0;
      else if (m_age[i] < 255) m_age[i] = m_age[i] + 1;
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back({8'(i), 1'(m_key[i]), 7'(m_note[i]), 7'(m_vel[i])});
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 4 * NV + 8) begin
      @(posedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; ev_valid = 1'b0; panic = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  task automatic send_ev(input logic on, input int n, input int v);
    int t = 0;
    @(negedge clk);
    ev_valid = 1'b1; ev_on = on; ev_note = 7'(n); ev_velocity = 7'(v);
    while (!ev_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_idle", ev_ready, 1);
    @(posedge clk);
    #1 ev_valid = 1'b0;
    check("ready_scan", ev_ready, 0);
    repeat (NV) @(posedge clk);
    #1 check("ready_commit", ev_ready, 0);
    @(posedge clk);
    #1 check("ready_back", ev_ready, 1);
    model_apply(on, n, v);
    repeat (2) @(posedge clk);
    push_frame();
    drain();
  endtask

  // Monitor: compares each slot's outputs against the queued frame in index order.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset && !slot_phase && exp_q.size() != 0) begin
      if (voice_index == exp_q[0][EW-1:EW-8]) begin
        e = exp_q.pop_front();
        check("slot", {9'd0, voice_index, key_state, voice_note, voice_velocity}, {9'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset values and free-running sweep.
    do_reset();
    #1;
    check("rst_idx", voice_index, 0);
    check("rst_phase", slot_phase, 0);
    check("rst_frame", frame_start, 1);
    check("rst_key", key_state, 0);
    check("rst_note", voice_note, 0);
    check("rst_vel", voice_velocity, 0);
    check("rst_ready", ev_ready, 1);
    for (int k = 1; k <= 2 * NV + 2; k++) begin
      @(negedge clk);
      check("sweep_idx", voice_index, (k / 2) % NV);
      check("sweep_phase", slot_phase, k % 2);
      check("sweep_frame", frame_start, ((k / 2) % NV) == 0);
      check("sweep_key", key_state, 0);
    end

    // Simple allocation.
    send_ev(1'b1, 60, 100);
    send_ev(1'b1, 64, 90);

    // Release keeps note, then reallocation by age.
    do_reset();
    send_ev(1'b1, 60, 100);
    send_ev(1'b0, 60, 0);
    send_ev(1'b1, 67, 80);

    // Fill all voices, steal the oldest, stale note-off.
    do_reset();
    for (int i = 0; i < NV; i++) send_ev(1'b1, 40 + i, 20 + i);
    send_ev(1'b1, 70, 99);
    send_ev(1'b0, 40, 0);

    // Retrigger and unknown note-off.
    do_reset();
    send_ev(1'b1, 60, 50);
    send_ev(1'b1, 60, 120);
    send_ev(1'b0, 30, 0);

    // Panic during SCAN of note-on 72.
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd72; ev_velocity = 7'd90;
    #1 check("pre_panic_ready", ev_ready, 1);
    @(posedge clk);
    #1 ev_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    panic = 1'b1;
    #1 check("panic_ready", ev_ready, 0);
    @(negedge clk);
    panic = 1'b0;
    #1 check("post_panic_ready", ev_ready, 1);
    for (int i = 0; i < NV; i++) m_key[i] = 0;
    repeat (NV + 4) @(posedge clk);
    #1 check("panic_idle", ev_ready, 1);
    push_frame();
    drain();
    send_ev(1'b1, 80, 33);

    // Reset in the middle of a scan.
    send_ev(1'b1, 50, 60);
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd51; ev_velocity = 7'd61;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_idx", voice_index, 0);
    check("mid_rst_phase", slot_phase, 0);
    check("mid_rst_frame", frame_start, 1);
    check("mid_rst_key", key_state, 0);
    check("mid_rst_note", voice_note, 0);
    check("mid_rst_ready", ev_ready, 1);
    @(negedge clk);
    model_reset();
    exp_q.delete();
    reset = 1'b1;
    push_frame();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
